// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the write-back arbiter.
// The macro defaults below apply only when xgriscv_defines.v has not already been read.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef RFREG_NUM
`define RFREG_NUM 32
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 2
`endif
`ifndef WB_MAX_WAIT
`define WB_MAX_WAIT 4
`endif

package wb_arbiter_pkg;
    localparam int XLEN        = `XLEN;
    localparam int RFIDX_W     = `RFIDX_WIDTH;
    localparam int ADDR_W      = `ADDR_SIZE;
    localparam int RFREG_NUM   = `RFREG_NUM;
    localparam int WB_DEPTH    = `WB_FIFO_DEPTH;
    localparam int WB_MAX_WAIT = `WB_MAX_WAIT;

    typedef struct packed {
        logic [RFIDX_W-1:0] wa;
        logic [XLEN-1:0]    wd;
        logic [ADDR_W-1:0]  pc;
    } wb_entry_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the WB stage / MDU / decode and the arbiter.
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic               pipe_we;
    logic [RFIDX_W-1:0] pipe_wa;
    logic [XLEN-1:0]    pipe_wd;
    logic [ADDR_W-1:0]  pipe_pc;
    logic               mdu_valid;
    logic               mdu_ready;
    logic [RFIDX_W-1:0] mdu_wa;
    logic [XLEN-1:0]    mdu_wd;
    logic [ADDR_W-1:0]  mdu_pc;
    logic               iss_valid;
    logic [RFIDX_W-1:0] iss_wa;
    logic [RFIDX_W-1:0] rs1_idx;
    logic [RFIDX_W-1:0] rs2_idx;
    logic [RFIDX_W-1:0] rd_idx;
    logic               busy_rs1;
    logic               busy_rs2;
    logic               busy_rd;
    logic               pipe_stall;
    logic               rf_we;
    logic [RFIDX_W-1:0] rf_wa;
    logic [XLEN-1:0]    rf_wd;
    logic [ADDR_W-1:0]  rf_pc;

    modport slave (
        input  pipe_we, pipe_wa, pipe_wd, pipe_pc,
        input  mdu_valid, mdu_wa, mdu_wd, mdu_pc,
        input  iss_valid, iss_wa, rs1_idx, rs2_idx, rd_idx,
        output mdu_ready, busy_rs1, busy_rs2, busy_rd, pipe_stall,
        output rf_we, rf_wa, rf_wd, rf_pc
    );

    modport master (
        output pipe_we, pipe_wa, pipe_wd, pipe_pc,
        output mdu_valid, mdu_wa, mdu_wd, mdu_pc,
        output iss_valid, iss_wa, rs1_idx, rs2_idx, rd_idx,
        input  mdu_ready, busy_rs1, busy_rs2, busy_rd, pipe_stall,
        input  rf_we, rf_wa, rf_wd, rf_pc
    );
endinterface

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with full/empty flags; head is visible on o_dout.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Merges WB-stage and buffered MDU results onto the regfile write port,
// tracks pending MDU destinations and stalls the pipe when MDU results starve.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH    = WB_DEPTH,
    parameter int MAX_WAIT = WB_MAX_WAIT
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    wb_entry_t            w_head;
    wb_entry_t            w_mdu_entry;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_pipe_sel;
    logic                 w_push;
    logic                 w_pop;
    logic [RFREG_NUM-1:0] r_sb;
    logic [CW-1:0]        r_wait;
    logic                 r_stall;

    // A write to x0 from the pipe is treated as an idle slot the FIFO may use.
    assign w_pipe_sel = bus.pipe_we && (bus.pipe_wa != '0);
    assign w_pop      = !reset && !w_empty && !w_pipe_sel;

    assign bus.mdu_ready = !w_full && !reset;
    assign w_push        = bus.mdu_valid && bus.mdu_ready && (bus.mdu_wa != '0);
    assign w_mdu_entry   = '{wa: bus.mdu_wa, wd: bus.mdu_wd, pc: bus.mdu_pc};

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   (w_mdu_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.rf_we = !reset && (w_pipe_sel || !w_empty);
    assign bus.rf_wa = w_pop ? w_head.wa : bus.pipe_wa;
    assign bus.rf_wd = w_pop ? w_head.wd : bus.pipe_wd;
    assign bus.rf_pc = w_pop ? w_head.pc : bus.pipe_pc;

    assign bus.busy_rs1   = !reset && r_sb[bus.rs1_idx] && (bus.rs1_idx != '0);
    assign bus.busy_rs2   = !reset && r_sb[bus.rs2_idx] && (bus.rs2_idx != '0);
    assign bus.busy_rd    = !reset && r_sb[bus.rd_idx]  && (bus.rd_idx  != '0);
    assign bus.pipe_stall = r_stall;

    // Set is applied after clear so a same-index issue keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sb <= '0;
        end else begin
            if (w_pop) r_sb[w_head.wa] <= 1'b0;
            if (bus.iss_valid && (bus.iss_wa != '0)) r_sb[bus.iss_wa] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else if (w_pop) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else if (w_empty) begin
            r_wait  <= '0;
        end else if (r_wait == WAIT_LAST) begin
            r_stall <= 1'b1;
        end else begin
            r_wait  <= r_wait + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and randomized checks of wb_arbiter against a queue-based reference model.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: pending results as a queue, pending registers as a bit set,
    // and the number of consecutive cycles the current head has been refused.
    wb_entry_t            m_q[$];
    logic [RFREG_NUM-1:0] m_sb = '0;
    int                   m_denied = 0;
    logic                 m_stall = 1'b0;

    function automatic logic m_pipe_sel();
        return bus.pipe_we && (bus.pipe_wa != 0);
    endfunction

    always @(posedge clk) begin
        logic acc;
        logic pop;
        if (reset) begin
            m_q.delete();
            m_sb     = '0;
            m_denied = 0;
            m_stall  = 1'b0;
        end else begin
            acc = bus.mdu_valid && (m_q.size() < DEPTH) && (bus.mdu_wa != 0);
            pop = !m_pipe_sel() && (m_q.size() != 0);
            if (pop) begin
                m_sb[m_q[0].wa] = 1'b0;
                void'(m_q.pop_front());
                m_denied = 0;
                m_stall  = 1'b0;
            end else if (m_q.size() != 0) begin
                m_denied++;
                if (m_denied >= MAX_WAIT) m_stall = 1'b1;
            end else begin
                m_denied = 0;
            end
            if (bus.iss_valid && bus.iss_wa != 0) m_sb[bus.iss_wa] = 1'b1;
            if (acc) m_q.push_back('{wa: bus.mdu_wa, wd: bus.mdu_wd, pc: bus.mdu_pc});
        end
    end

    task automatic drive_idle();
        bus.pipe_we   = 1'b0; bus.pipe_wa = '0; bus.pipe_wd = '0; bus.pipe_pc = '0;
        bus.mdu_valid = 1'b0; bus.mdu_wa  = '0; bus.mdu_wd  = '0; bus.mdu_pc  = '0;
        bus.iss_valid = 1'b0; bus.iss_wa  = '0;
        bus.rs1_idx   = '0;   bus.rs2_idx = '0; bus.rd_idx  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd3;
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd4;
        bus.rs1_idx = 5'd4; bus.rs2_idx = 5'd4; bus.rd_idx = 5'd4;
        for (int c = 0; c < 2; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            n_cmp++; if (bus.mdu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.mdu_ready); end
            n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
            n_cmp++; if ({bus.busy_rs1, bus.busy_rs2, bus.busy_rd} !== 3'b000) begin n_bad++;
                $display("FAIL reset_busy: got %b want 000", {bus.busy_rs1, bus.busy_rs2, bus.busy_rd}); end
        end
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        bus.rs1_idx = 5'd4;
        #1;
        n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", bus.mdu_ready); end
        n_cmp++; if ({bus.rf_we, bus.pipe_stall, bus.busy_rs1} !== 3'b000) begin n_bad++;
            $display("FAIL post_reset_state: got we/stall/busy %b want 000", {bus.rf_we, bus.pipe_stall, bus.busy_rs1}); end
    endtask

    task automatic test_mdu_only();
        @(negedge clk); drive_idle();
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd5;
        @(negedge clk); drive_idle();
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd5; bus.mdu_wd = 32'h1234_5678; bus.mdu_pc = 32'h100;
        bus.rs1_idx = 5'd5;
        #1;
        n_cmp++; if ({bus.busy_rs1, bus.rf_we} !== 2'b10) begin n_bad++;
            $display("FAIL mdu_accept_cycle: got busy/we %b want 10", {bus.busy_rs1, bus.rf_we}); end
        @(negedge clk); drive_idle();
        bus.rs1_idx = 5'd5;
        #1;
        n_cmp++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd, bus.rf_pc} !== {1'b1, 5'd5, 32'h1234_5678, 32'h100}) begin n_bad++;
            $display("FAIL mdu_write: got we=%b wa=%0d wd=%h pc=%h want we=1 wa=5 wd=12345678 pc=100",
                     bus.rf_we, bus.rf_wa, bus.rf_wd, bus.rf_pc); end
        n_cmp++; if (bus.busy_rs1 !== 1'b1) begin n_bad++; $display("FAIL mdu_busy_before_pop: got %b want 1", bus.busy_rs1); end
        @(negedge clk); drive_idle();
        bus.rs1_idx = 5'd5;
        #1;
        n_cmp++; if ({bus.busy_rs1, bus.rf_we} !== 2'b00) begin n_bad++;
            $display("FAIL mdu_after_pop: got busy/we %b want 00", {bus.busy_rs1, bus.rf_we}); end
    endtask

    task automatic test_priority();
        @(negedge clk); drive_idle();
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd7; bus.mdu_wd = 32'h77;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); drive_idle();
            bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h33;
            #1;
            n_cmp++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd3, 32'h33}) begin n_bad++;
                $display("FAIL prio_pipe_%0d: got we=%b wa=%0d wd=%h want we=1 wa=3 wd=33", c, bus.rf_we, bus.rf_wa, bus.rf_wd); end
        end
        @(negedge clk); drive_idle();
        #1;
        n_cmp++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd7, 32'h77}) begin n_bad++;
            $display("FAIL prio_fifo: got we=%b wa=%0d wd=%h want we=1 wa=7 wd=77", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        @(negedge clk); drive_idle();
        #1;
        n_cmp++; if ({bus.rf_we, bus.pipe_stall} !== 2'b00) begin n_bad++;
            $display("FAIL prio_drained: got we/stall %b want 00", {bus.rf_we, bus.pipe_stall}); end
    endtask

    task automatic test_starvation();
        @(negedge clk); drive_idle();
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd8; bus.mdu_wd = 32'h88;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk); drive_idle();
            bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3; bus.pipe_wd = 32'h30 + k;
            #1;
            n_cmp++; if ({bus.rf_wa, bus.pipe_stall} !== {5'd3, (k > MAX_WAIT)}) begin n_bad++;
                $display("FAIL starve_cycle_%0d: got wa=%0d stall=%b want wa=3 stall=%b", k, bus.rf_wa, bus.pipe_stall, (k > MAX_WAIT)); end
        end
        @(negedge clk); drive_idle();
        #1;
        n_cmp++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd, bus.pipe_stall} !== {1'b1, 5'd8, 32'h88, 1'b1}) begin n_bad++;
            $display("FAIL starve_release: got we=%b wa=%0d wd=%h stall=%b want we=1 wa=8 wd=88 stall=1",
                     bus.rf_we, bus.rf_wa, bus.rf_wd, bus.pipe_stall); end
        @(negedge clk); drive_idle();
        #1;
        n_cmp++; if ({bus.rf_we, bus.pipe_stall} !== 2'b00) begin n_bad++;
            $display("FAIL starve_cleared: got we/stall %b want 00", {bus.rf_we, bus.pipe_stall}); end
    endtask

    task automatic test_full();
        logic [4:0] exp_wa [3] = '{5'd10, 5'd11, 5'd12};
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); drive_idle();
            bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3;
            bus.mdu_valid = 1'b1; bus.mdu_wa = (c < 2) ? 5'(10 + c) : 5'd12; bus.mdu_wd = 32'hA0 + c;
            #1;
            n_cmp++; if ({bus.mdu_ready, bus.rf_wa} !== {(c < 2), 5'd3}) begin n_bad++;
                $display("FAIL full_fill_%0d: got ready=%b wa=%0d want ready=%b wa=3", c, bus.mdu_ready, bus.rf_wa, (c < 2)); end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); drive_idle();
            bus.mdu_valid = (c < 2); bus.mdu_wa = 5'd12; bus.mdu_wd = 32'hA3;
            #1;
            n_cmp++; if ({bus.rf_we, bus.rf_wa, bus.mdu_ready} !== {1'b1, exp_wa[c], (c != 0)}) begin n_bad++;
                $display("FAIL full_drain_%0d: got we=%b wa=%0d ready=%b want we=1 wa=%0d ready=%b",
                         c, bus.rf_we, bus.rf_wa, bus.mdu_ready, exp_wa[c], (c != 0)); end
        end
        @(negedge clk); drive_idle();
        #1;
        n_cmp++; if ({bus.rf_we, bus.pipe_stall} !== 2'b00) begin n_bad++;
            $display("FAIL full_empty: got we/stall %b want 00", {bus.rf_we, bus.pipe_stall}); end
    endtask

    task automatic test_corners();
        // x0 result is swallowed
        @(negedge clk); drive_idle();
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd0; bus.mdu_wd = 32'hDEAD;
        #1;
        n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b want 1", bus.mdu_ready); end
        @(negedge clk); drive_idle();
        #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL x0_discard: got rf_we %b want 0", bus.rf_we); end
        // reissue x9 while its previous result pops
        @(negedge clk); drive_idle();
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd9;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd9; bus.mdu_wd = 32'h99;
        @(negedge clk); drive_idle();
        bus.iss_valid = 1'b1; bus.iss_wa = 5'd9;
        #1;
        n_cmp++; if ({bus.rf_we, bus.rf_wa} !== {1'b1, 5'd9}) begin n_bad++;
            $display("FAIL sb_pop_x9: got we=%b wa=%0d want we=1 wa=9", bus.rf_we, bus.rf_wa); end
        @(negedge clk); drive_idle();
        bus.rs2_idx = 5'd9;
        #1;
        n_cmp++; if (bus.busy_rs2 !== 1'b1) begin n_bad++; $display("FAIL sb_set_wins: got busy_rs2 %b want 1", bus.busy_rs2); end
        // pipe write to x0 lets the FIFO drain
        @(negedge clk); drive_idle();
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd6; bus.mdu_wd = 32'h66;
        @(negedge clk); drive_idle();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd0; bus.pipe_wd = 32'hBAD;
        #1;
        n_cmp++; if ({bus.rf_we, bus.rf_wa, bus.rf_wd} !== {1'b1, 5'd6, 32'h66}) begin n_bad++;
            $display("FAIL pipe_x0_drain: got we=%b wa=%0d wd=%h want we=1 wa=6 wd=66", bus.rf_we, bus.rf_wa, bus.rf_wd); end
        @(negedge clk); drive_idle();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd0;
        #1;
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL pipe_x0_idle: got rf_we %b want 0", bus.rf_we); end
    endtask

    task automatic test_mid_reset();
        @(negedge clk); drive_idle();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd13; bus.iss_valid = 1'b1; bus.iss_wa = 5'd15;
        @(negedge clk); drive_idle();
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3;
        bus.mdu_valid = 1'b1; bus.mdu_wa = 5'd14;
        @(negedge clk); drive_idle();
        reset = 1'b1;
        bus.pipe_we = 1'b1; bus.pipe_wa = 5'd3;
        #1;
        n_cmp++; if ({bus.rf_we, bus.mdu_ready} !== 2'b00) begin n_bad++;
            $display("FAIL midreset_gate: got we/ready %b want 00", {bus.rf_we, bus.mdu_ready}); end
        @(negedge clk); drive_idle();
        reset = 1'b0;
        bus.rs1_idx = 5'd15; bus.rs2_idx = 5'd13;
        #1;
        n_cmp++; if ({bus.rf_we, bus.busy_rs1, bus.busy_rs2, bus.mdu_ready, bus.pipe_stall} !== 5'b00010) begin n_bad++;
            $display("FAIL midreset_flush: got we/b1/b2/ready/stall %b want 00010",
                     {bus.rf_we, bus.busy_rs1, bus.busy_rs2, bus.mdu_ready, bus.pipe_stall}); end
    endtask

    task automatic test_random();
        logic [4:0]  cand;
        logic        fifo_sel;
        wb_entry_t   exp_e;
        logic [2:0]  exp_busy;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); drive_idle();
            reset         = ($urandom_range(0, 63) == 0);
            bus.pipe_we   = ($urandom_range(0, 9) < 7);
            bus.pipe_wa   = 5'($urandom_range(0, 31));
            bus.pipe_wd   = $urandom;
            bus.pipe_pc   = $urandom;
            bus.mdu_valid = ($urandom_range(0, 9) < 4);
            bus.mdu_wa    = 5'($urandom_range(0, 31));
            bus.mdu_wd    = $urandom;
            bus.mdu_pc    = $urandom;
            cand          = 5'($urandom_range(1, 31));
            bus.iss_valid = ($urandom_range(0, 2) == 0) && !m_sb[cand];
            bus.iss_wa    = cand;
            bus.rd_idx    = bus.iss_valid ? cand : 5'($urandom_range(0, 31));
            bus.rs1_idx   = 5'($urandom_range(0, 31));
            bus.rs2_idx   = 5'($urandom_range(0, 31));
            #1;
            fifo_sel = !reset && !m_pipe_sel() && (m_q.size() != 0);
            exp_e    = fifo_sel ? m_q[0] : '{wa: bus.pipe_wa, wd: bus.pipe_wd, pc: bus.pipe_pc};
            exp_busy = reset ? 3'b000 : {m_sb[bus.rs1_idx] && bus.rs1_idx != 0,
                                         m_sb[bus.rs2_idx] && bus.rs2_idx != 0,
                                         m_sb[bus.rd_idx]  && bus.rd_idx  != 0};
            n_cmp++; if (bus.rf_we !== (!reset && (m_pipe_sel() || m_q.size() != 0))) begin n_bad++;
                $display("FAIL rnd_rf_we c%0d: got %b want %b", c, bus.rf_we, (!reset && (m_pipe_sel() || m_q.size() != 0))); end
            n_cmp++; if ({bus.rf_wa, bus.rf_wd, bus.rf_pc} !== exp_e) begin n_bad++;
                $display("FAIL rnd_rf_data c%0d: got %h want %h", c, {bus.rf_wa, bus.rf_wd, bus.rf_pc}, exp_e); end
            n_cmp++; if (bus.mdu_ready !== (!reset && m_q.size() < DEPTH)) begin n_bad++;
                $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.mdu_ready, (!reset && m_q.size() < DEPTH)); end
            n_cmp++; if ({bus.busy_rs1, bus.busy_rs2, bus.busy_rd} !== exp_busy) begin n_bad++;
                $display("FAIL rnd_busy c%0d: got %b want %b", c, {bus.busy_rs1, bus.busy_rs2, bus.busy_rd}, exp_busy); end
            n_cmp++; if (bus.pipe_stall !== m_stall) begin n_bad++;
                $display("FAIL rnd_stall c%0d: got %b want %b", c, bus.pipe_stall, m_stall); end
            if (bus.iss_valid) begin
                n_cmp++; if (bus.busy_rd !== 1'b0) begin n_bad++;
                    $display("FAIL rnd_issue_on_busy c%0d: got busy_rd %b want 0", c, bus.busy_rd); end
            end
        end
        @(negedge clk); drive_idle();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mdu_only();
        test_priority();
        test_starvation();
        test_full();
        test_corners();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
